tone_synth: RTL and testbench

TONE_SYNTH -- requirements
Module: tone_synth

---
 rtl/tone_synth_pkg.sv | 32 +++
 rtl/tone_synth_channel.sv | 132 +++++++++++++
 rtl/tone_synth.sv | 88 ++++++++
 tb/tb_tone_synth.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_synth_pkg.sv
// Shared types and constants for the tone synthesizer.
//   ch_state_t  : per-channel sequencing state
//   BASE_HP     : octave-0 half-periods (in prescale ticks) for do..si
//   REST_MIN    : first tone index treated as a rest
//   half_period : effective half-period for a tone/octave pair, never below 1
package tone_synth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } ch_state_t;

   localparam int HP_W = 10;

   localparam logic [3:0] REST_MIN = 4'd12;

   localparam logic [HP_W-1:0] BASE_HP [12] = '{
      10'd746, 10'd705, 10'd665, 10'd628, 10'd593, 10'd559,
      10'd528, 10'd498, 10'd470, 10'd444, 10'd419, 10'd395
   };

   // Rests return 1; their half-period is never used to toggle the output.
   function automatic logic [HP_W-1:0] half_period(input logic [3:0]  tone,
                                                   input logic [31:0] oct);
      logic [HP_W-1:0] shifted;
      shifted = '0;
      if (tone < REST_MIN) shifted = BASE_HP[tone] >> oct;
      return (shifted == '0) ? HP_W'(1) : shifted;
   endfunction

endpackage

// File: rtl/tone_synth_channel.sv
// One tone channel: accepts a note, plays a square wave for the note length,
// then holds a silent gap before becoming ready again.
//   clk, reset        : system clock, synchronous active-high reset
//   tick_pre, tick_ms : shared prescale and millisecond strobes
//   note_valid/ready  : note handshake (ready only in IDLE)
//   note_tone/oct/dur : note fields, latched on acceptance
//   stop              : abort PLAY/GAP, ignored in IDLE
//   sq_out, busy      : registered square wave and PLAY/GAP indicator
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a note, note_ready high
// PLAY    | toggling sq_out every half-period, counting down duration
// GAP     | sq_out low, counting GAP_MS ms before returning to IDLE
module tone_channel
   import tone_synth_pkg::*;
#(
   parameter int OCT_W  = 3,
   parameter int DUR_W  = 12,
   parameter int GAP_MS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_pre,
   input  logic             tick_ms,
   input  logic             note_valid,
   output logic             note_ready,
   input  logic [3:0]       note_tone,
   input  logic [OCT_W-1:0] note_oct,
   input  logic [DUR_W-1:0] note_dur,
   input  logic             stop,
   output logic             sq_out,
   output logic             busy
);

   // Sized with +2 so the counter keeps a legal width when GAP_MS is 0.
   localparam int GAP_W = $clog2(GAP_MS + 2);

   ch_state_t        state;
   logic [3:0]       tone_q;
   logic [OCT_W-1:0] oct_q;
   logic [DUR_W-1:0] dur_cnt;
   logic [HP_W-1:0]  hp_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             sq_q;
   logic             ready_q;
   logic             busy_q;

   assign note_ready = ready_q;
   assign sq_out     = sq_q;
   assign busy       = busy_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         tone_q  <= '0;
         oct_q   <= '0;
         dur_cnt <= '0;
         hp_cnt  <= '0;
         gap_cnt <= '0;
         sq_q    <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (note_valid && ready_q) begin
                  tone_q  <= note_tone;
                  oct_q   <= note_oct;
                  dur_cnt <= note_dur;
                  hp_cnt  <= half_period(note_tone, 32'(note_oct)) - 1'b1;
                  sq_q    <= 1'b0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state   <= ST_PLAY;
               end else begin
                  ready_q <= 1'b1;
               end
            end

            ST_PLAY: begin
               if (stop) begin
                  sq_q    <= 1'b0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state   <= ST_IDLE;
               end else if (tick_ms && dur_cnt == DUR_W'(1)) begin
                  // dur_cnt never reaches 0 in PLAY here, so 0 means sustain.
                  dur_cnt <= '0;
                  sq_q    <= 1'b0;
                  if (GAP_MS == 0) begin
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state   <= ST_IDLE;
                  end else begin
                     gap_cnt <= GAP_W'(GAP_MS);
                     state   <= ST_GAP;
                  end
               end else begin
                  if (tick_ms && dur_cnt != '0) dur_cnt <= dur_cnt - 1'b1;
                  if (tick_pre) begin
                     if (hp_cnt == '0) begin
                        hp_cnt <= half_period(tone_q, 32'(oct_q)) - 1'b1;
                        if (tone_q < REST_MIN) sq_q <= ~sq_q;
                     end else begin
                        hp_cnt <= hp_cnt - 1'b1;
                     end
                  end
               end
            end

            ST_GAP: begin
               if (stop || (tick_ms && gap_cnt == GAP_W'(1))) begin
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state   <= ST_IDLE;
               end else if (tick_ms) begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end

            default: begin
               sq_q    <= 1'b0;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/tone_synth.sv
// Multi-channel square-wave tone synthesizer.
//   clk, reset          : system clock, synchronous active-high reset
//   note_valid/ready    : per-channel note handshake
//   note_tone/oct/dur   : per-channel note fields
//   stop                : per-channel abort
//   sq_out              : per-channel square wave
//   mix_out             : registered count of high sq_out bits (1-cycle lag)
//   busy                : per-channel PLAY/GAP indicator
// The prescale and millisecond strobes are shared free-running down-counters
// so all channels see the same time base.
module tone_synth
   import tone_synth_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int OCT_W      = 3,
   parameter int DUR_W      = 12,
   parameter int TICK_DIV   = 64,
   parameter int CLK_PER_MS = 50000,
   parameter int GAP_MS     = 10
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_CH-1:0]              note_valid,
   output logic [NUM_CH-1:0]              note_ready,
   input  logic [NUM_CH-1:0][3:0]         note_tone,
   input  logic [NUM_CH-1:0][OCT_W-1:0]   note_oct,
   input  logic [NUM_CH-1:0][DUR_W-1:0]   note_dur,
   input  logic [NUM_CH-1:0]              stop,
   output logic [NUM_CH-1:0]              sq_out,
   output logic [$clog2(NUM_CH+1)-1:0]    mix_out,
   output logic [NUM_CH-1:0]              busy
);

   localparam int PRE_W = $clog2(TICK_DIV + 1);
   localparam int MS_W  = $clog2(CLK_PER_MS + 1);
   localparam int MIX_W = $clog2(NUM_CH + 1);

   logic [PRE_W-1:0] pre_cnt;
   logic [MS_W-1:0]  ms_cnt;
   logic             tick_pre;
   logic             tick_ms;
   logic [MIX_W-1:0] mix_sum;

   assign tick_pre = (pre_cnt == '0);
   assign tick_ms  = (ms_cnt == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt <= PRE_W'(TICK_DIV - 1);
         ms_cnt  <= MS_W'(CLK_PER_MS - 1);
      end else begin
         pre_cnt <= tick_pre ? PRE_W'(TICK_DIV - 1) : pre_cnt - 1'b1;
         ms_cnt  <= tick_ms ? MS_W'(CLK_PER_MS - 1) : ms_cnt - 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      tone_channel #(
         .OCT_W  (OCT_W),
         .DUR_W  (DUR_W),
         .GAP_MS (GAP_MS)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .tick_pre   (tick_pre),
         .tick_ms    (tick_ms),
         .note_valid (note_valid[i]),
         .note_ready (note_ready[i]),
         .note_tone  (note_tone[i]),
         .note_oct   (note_oct[i]),
         .note_dur   (note_dur[i]),
         .stop       (stop[i]),
         .sq_out     (sq_out[i]),
         .busy       (busy[i])
      );
   end

   always_comb begin
      mix_sum = '0;
      for (int i = 0; i < NUM_CH; i++) mix_sum = mix_sum + MIX_W'(sq_out[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) mix_out <= '0;
      else       mix_out <= mix_sum;
   end

endmodule

// File: tb/tb_tone_synth.sv
// Testbench for tone_synth: half-period vector table, timed note sequences
// with closed-form expectations, and a mix_out scoreboard fed from sq_out.
module tb_tone_synth;

   localparam int NUM_CH     = 4;
   localparam int OCT_W      = 4;
   localparam int DUR_W      = 12;
   localparam int TICK_DIV   = 1;
   localparam int CLK_PER_MS = 2000;
   localparam int GAP_MS     = 2;
   localparam int MIX_W      = $clog2(NUM_CH + 1);

   logic                         clk = 1'b0;
   logic                         reset = 1'b1;
   logic [NUM_CH-1:0]            note_valid = '0;
   logic [NUM_CH-1:0]            note_ready;
   logic [NUM_CH-1:0][3:0]       note_tone = '0;
   logic [NUM_CH-1:0][OCT_W-1:0] note_oct = '0;
   logic [NUM_CH-1:0][DUR_W-1:0] note_dur = '0;
   logic [NUM_CH-1:0]            stop = '0;
   logic [NUM_CH-1:0]            sq_out;
   logic [MIX_W-1:0]             mix_out;
   logic [NUM_CH-1:0]            busy;

   tone_synth #(
      .NUM_CH     (NUM_CH),
      .OCT_W      (OCT_W),
      .DUR_W      (DUR_W),
      .TICK_DIV   (TICK_DIV),
      .CLK_PER_MS (CLK_PER_MS),
      .GAP_MS     (GAP_MS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .note_valid (note_valid),
      .note_ready (note_ready),
      .note_tone  (note_tone),
      .note_oct   (note_oct),
      .note_dur   (note_dur),
      .stop       (stop),
      .sq_out     (sq_out),
      .mix_out    (mix_out),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Non-reset edges since reset release; ms ticks land on multiples of CLK_PER_MS.
   int   cyc = 0;
   logic reset_q = 1'b1;
   always @(posedge clk) begin
      reset_q <= reset;
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string name, input int actual, input int required);
      vectors++;
      if (actual != required) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, required);
      end
   endtask

   // mix_out scoreboard: popcount of sq_out pushed each cycle, compared one cycle later.
   int mix_q[$];
   int exp_mix;
   always @(negedge clk) begin
      if (mix_q.size() > 0) begin
         exp_mix = mix_q.pop_front();
         if (reset_q) exp_mix = 0;
         check("mix_out_lag", int'(mix_out), exp_mix);
      end
      mix_q.push_back($countones(sq_out));
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      int tone;
      int oct;
      int exp_hp;
   } hp_vec_t;

   hp_vec_t hp_tab[7];
   int      hp_q[$];

   // Returns at a negedge whose following posedge is an ms tick.
   task automatic wait_align();
      int guard;
      guard = 0;
      @(negedge clk);
      while (((cyc + 1) % CLK_PER_MS) != 0 && guard < 3 * CLK_PER_MS) begin
         @(negedge clk);
         guard++;
      end
   endtask

   // Presents a note for one edge; returns at the negedge after acceptance.
   task automatic drive_note(input int ch, input int tone, input int oct, input int dur);
      note_valid[ch] = 1'b1;
      note_tone[ch]  = 4'(tone);
      note_oct[ch]   = OCT_W'(oct);
      note_dur[ch]   = DUR_W'(dur);
      @(negedge clk);
      note_valid[ch] = 1'b0;
   endtask

   task automatic stop_ch(input int ch);
      stop[ch] = 1'b1;
      @(negedge clk);
      stop[ch] = 1'b0;
   endtask

   // Note aligned to an ms tick: play lasts dur ms, then GAP_MS ms of silence.
   task automatic run_timed(input string tag, input int ch, input int tone, input int hp,
                            input int dur);
      int a, play_c, total_c, errs_sq, errs_busy, exp_sq;
      logic exp_busy;
      play_c    = dur * CLK_PER_MS;
      total_c   = (dur + GAP_MS) * CLK_PER_MS;
      errs_sq   = 0;
      errs_busy = 0;
      wait_align();
      drive_note(ch, tone, 0, dur);
      a = cyc;
      for (int n = 0; n <= total_c; n++) begin
         if (n != 0) @(negedge clk);
         exp_sq   = (tone < 12 && n < play_c) ? ((n / hp) % 2) : 0;
         exp_busy = (n < total_c);
         if (sq_out[ch] !== exp_sq[0]) errs_sq++;
         if (busy[ch] !== exp_busy) errs_busy++;
      end
      check({tag, "_sq_errs"}, errs_sq, 0);
      check({tag, "_busy_errs"}, errs_busy, 0);
      check({tag, "_ready_after"}, int'(note_ready[ch]), 1);
      check({tag, "_elapsed"}, cyc - a, total_c);
   endtask

   initial begin
      int n1, n2, n, exp, errs_mix, errs_sq, first_ready, sqv, a;
      logic prev;

      hp_tab[0] = '{tone: 9,  oct: 0,  exp_hp: 444};
      hp_tab[1] = '{tone: 9,  oct: 3,  exp_hp: 55};
      hp_tab[2] = '{tone: 11, oct: 7,  exp_hp: 3};
      hp_tab[3] = '{tone: 0,  oct: 10, exp_hp: 1};
      hp_tab[4] = '{tone: 0,  oct: 15, exp_hp: 1};
      hp_tab[5] = '{tone: 4,  oct: 2,  exp_hp: 148};
      hp_tab[6] = '{tone: 7,  oct: 1,  exp_hp: 249};

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_sq", int'(sq_out), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_mix", int'(mix_out), 0);
      check("rst_ready", int'(note_ready), 0);
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_rst", int'(note_ready), 4'hF);

      // Timed note on ch0: tone 9 oct 0 dur 2, then a rest on ch1
      run_timed("seq_tone9", 0, 9, 444, 2);
      run_timed("seq_rest13", 1, 13, 1, 3);

      // Half-period table on ch0 with sustained notes
      foreach (hp_tab[i]) begin
         @(negedge clk);
         hp_q.push_back(hp_tab[i].exp_hp);
         drive_note(0, hp_tab[i].tone, hp_tab[i].oct, 0);
         n1 = -1;
         n2 = -1;
         prev = sq_out[0];
         for (int k = 1; k <= 2000 && n2 < 0; k++) begin
            @(negedge clk);
            if (sq_out[0] !== prev) begin
               if (n1 < 0) n1 = k;
               else        n2 = k;
               prev = sq_out[0];
            end
         end
         exp = hp_q.pop_front();
         check($sformatf("hp_first_t%0d_o%0d", hp_tab[i].tone, hp_tab[i].oct), n1, exp);
         check($sformatf("hp_period_t%0d_o%0d", hp_tab[i].tone, hp_tab[i].oct),
               (n2 < 0 || n1 < 0) ? -1 : n2 - n1, exp);
         stop_ch(0);
         check("hp_stop_ready", int'(note_ready[0]), 1);
         check("hp_stop_sq", int'(sq_out[0]), 0);
      end

      // Sustain then stop on ch2: tone 5 (hp 559)
      @(negedge clk);
      drive_note(2, 5, 0, 0);
      repeat (10000) @(negedge clk);
      check("sus_busy", int'(busy[2]), 1);
      check("sus_sq_before_stop", int'(sq_out[2]), (10000 / 559) % 2);
      stop_ch(2);
      check("sus_stop_sq", int'(sq_out[2]), 0);
      check("sus_stop_ready", int'(note_ready[2]), 1);
      check("sus_stop_busy", int'(busy[2]), 0);
      @(negedge clk);
      check("sus_no_gap", int'(busy[2]), 0);

      // Four channels, tone 4, valid held high across the whole note
      wait_align();
      for (int c = 0; c < NUM_CH; c++) begin
         note_valid[c] = 1'b1;
         note_tone[c]  = 4'd4;
         note_oct[c]   = '0;
         note_dur[c]   = DUR_W'(1);
      end
      @(negedge clk);
      a = cyc;
      errs_mix = 0;
      errs_sq = 0;
      first_ready = -1;
      for (int k = 0; k <= 6000; k++) begin
         if (k != 0) @(negedge clk);
         n = cyc - a;
         sqv = (n < 2000) ? ((n / 593) % 2) : 0;
         if (sq_out !== (sqv != 0 ? 4'hF : 4'h0)) errs_sq++;
         if (n >= 1 && n <= 2001) begin
            exp = (n - 1 < 2000) ? 4 * (((n - 1) / 593) % 2) : 0;
            if (int'(mix_out) != exp) errs_mix++;
         end
         if (first_ready < 0 && note_ready[0] === 1'b1) first_ready = n;
      end
      check("mix4_sq_errs", errs_sq, 0);
      check("mix4_mix_errs", errs_mix, 0);
      check("held_ready_cycle", first_ready, 6000);
      @(negedge clk);
      check("held_reaccept_ready", int'(note_ready), 0);
      check("held_reaccept_busy", int'(busy), 4'hF);
      note_valid = '0;
      stop = 4'hF;
      @(negedge clk);
      stop = '0;
      check("held_stop_ready", int'(note_ready), 4'hF);

      // Reset pulsed mid-PLAY
      @(negedge clk);
      note_valid[3] = 1'b1; note_tone[3] = 4'd0; note_oct[3] = 4'd15; note_dur[3] = '0;
      note_valid[0] = 1'b1; note_tone[0] = 4'd2; note_oct[0] = 4'd0;  note_dur[0] = DUR_W'(5);
      @(negedge clk);
      note_valid = '0;
      repeat (50) @(negedge clk);
      check("pre_rst_busy", int'(busy), 4'b1001);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_sq", int'(sq_out), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_mix", int'(mix_out), 0);
      check("midrst_ready", int'(note_ready), 0);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_ready_after", int'(note_ready), 4'hF);
      repeat (3) @(negedge clk);
      check("midrst_no_gap", int'(busy), 0);

      // stop together with valid in IDLE: note is accepted
      note_valid[1] = 1'b1; stop[1] = 1'b1;
      note_tone[1] = 4'd3; note_oct[1] = '0; note_dur[1] = '0;
      @(negedge clk);
      note_valid[1] = 1'b0; stop[1] = 1'b0;
      check("stopvalid_busy", int'(busy[1]), 1);
      check("stopvalid_ready", int'(note_ready[1]), 0);
      stop_ch(1);
      check("stopvalid_end_ready", int'(note_ready[1]), 1);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
